// File: rtl/fp32_16_arb.sv
`default_nettype none
// ============================================================================
// Module   : fp32_16_arb
// Summary  : Round-robin arbiter sharing one fp32->fp16 converter between two
//            requesters, with a 1-deep registered output and event counters.
// Revision : 1.0
// ============================================================================
module fp32_16_arb #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [31:0]      a_data,
    input  logic [TAG_W-1:0] a_tag,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [31:0]      b_data,
    input  logic [TAG_W-1:0] b_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_src,
    output logic [TAG_W-1:0] out_tag,
    output logic [2:0]       out_flags,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_conv,
    output logic [CNT_W-1:0] cnt_exc
);

    localparam logic c_SRC_A = 1'b0;
    localparam logic c_SRC_B = 1'b1;

    logic             r_out_valid;
    logic [15:0]      r_out_data;
    logic             r_out_src;
    logic [TAG_W-1:0] r_out_tag;
    logic [2:0]       r_out_flags;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_cnt_conv;
    logic [CNT_W-1:0] r_cnt_exc;

    logic        w_can_accept;
    logic        w_grant_a;
    logic        w_grant_b;
    logic        w_xfer;
    logic [31:0] w_sel_data;

    assign w_can_accept = !r_out_valid | out_ready;
    assign w_grant_a    = a_valid & (!b_valid | (r_last_grant == c_SRC_B));
    assign w_grant_b    = b_valid & (!a_valid | (r_last_grant == c_SRC_A));
    assign a_ready      = !rst & w_can_accept & w_grant_a;
    assign b_ready      = !rst & w_can_accept & w_grant_b;
    assign w_xfer       = a_ready | b_ready;
    assign w_sel_data   = w_grant_b ? b_data : a_data;

    logic               w_sign;
    logic [7:0]         w_exp;
    logic [22:0]        w_frac;
    logic [23:0]        w_mant;
    logic signed [9:0]  w_half_exp;
    logic signed [9:0]  w_den;
    logic [5:0]         w_sh;
    logic [63:0]        w_wide;
    logic [9:0]         w_kept;
    logic               w_guard;
    logic               w_sticky;
    logic               w_round_up;
    logic [14:0]        w_base;
    logic [14:0]        w_mag;
    logic [15:0]        w_res;
    logic [2:0]         w_flags;

    // Normal and subnormal results share one shifter: normals drop 13 bits,
    // subnormals drop 13+(1-e); past 27 extra bits only the sticky survives.
    always_comb begin
        w_sign     = w_sel_data[31];
        w_exp      = w_sel_data[30:23];
        w_frac     = w_sel_data[22:0];
        w_mant     = {1'b1, w_frac};
        w_half_exp = $signed({2'b00, w_exp}) - 10'sd112;
        w_den      = 10'sd1 - w_half_exp;
        if (w_half_exp >= 10'sd1)
            w_sh = 6'd13;
        else if (w_den > 10'sd27)
            w_sh = 6'd40;
        else
            w_sh = 6'd13 + w_den[5:0];
        w_wide     = {40'd0, w_mant};
        w_kept     = 10'(w_wide >> w_sh);
        w_guard    = w_wide[w_sh - 6'd1];
        w_sticky   = |(w_wide & ((64'd1 << (w_sh - 6'd1)) - 64'd1));
        w_round_up = w_guard & (w_sticky | w_kept[0]);
        w_base     = (w_half_exp >= 10'sd1) ? {w_half_exp[4:0], w_kept} : {5'd0, w_kept};
        w_mag      = w_base + {14'd0, w_round_up};
        w_res      = {w_sign, w_mag};
        w_flags    = 3'b000;
        if (w_exp == 8'hFF) begin
            if (w_frac == 23'd0) begin
                w_res = {w_sign, 5'h1F, 10'd0};
            end else begin
                w_res   = {w_sign, 5'h1F, w_frac[22], 9'h001};
                w_flags = 3'b100;
            end
        end else if (w_exp == 8'h00) begin
            w_res      = {w_sign, 15'd0};
            w_flags[0] = (w_frac != 23'd0);
        end else if ((w_half_exp >= 10'sd31) || (w_mag[14:10] == 5'h1F)) begin
            w_res   = {w_sign, 5'h1F, 10'd0};
            w_flags = 3'b010;
        end else if (w_mag[14:10] == 5'd0) begin
            w_flags = 3'b001;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= 16'd0;
            r_out_src    <= 1'b0;
            r_out_tag    <= '0;
            r_out_flags  <= 3'b000;
            r_last_grant <= c_SRC_B;
            r_cnt_conv   <= '0;
            r_cnt_exc    <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= w_res;
                r_out_src    <= w_grant_b;
                r_out_tag    <= w_grant_b ? b_tag : a_tag;
                r_out_flags  <= w_flags;
                r_last_grant <= w_grant_b ? c_SRC_B : c_SRC_A;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (clr_cnt) begin
                r_cnt_conv <= '0;
                r_cnt_exc  <= '0;
            end else if (w_xfer) begin
                r_cnt_conv <= r_cnt_conv + {{(CNT_W-1){1'b0}}, 1'b1};
                if (w_flags != 3'b000)
                    r_cnt_exc <= r_cnt_exc + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_tag   = r_out_tag;
    assign out_flags = r_out_flags;
    assign cnt_conv  = r_cnt_conv;
    assign cnt_exc   = r_cnt_exc;

endmodule
`default_nettype wire

// File: tb/tb_fp32_16_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_16_arb
// Summary  : Randomized bench for fp32_16_arb against a value-level reference.
// Revision : 1.0
// ============================================================================
module tb_fp32_16_arb;

    localparam int TAG_W = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_valid, b_valid, out_ready, clr_cnt;
    logic [31:0]      a_data, b_data;
    logic [TAG_W-1:0] a_tag, b_tag;
    logic             a_ready, b_ready, out_valid, out_src;
    logic [15:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       out_flags;
    logic [CNT_W-1:0] cnt_conv, cnt_exc;

    fp32_16_arb #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_tag(a_tag),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_tag(b_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .out_tag(out_tag), .out_flags(out_flags),
        .clr_cnt(clr_cnt), .cnt_conv(cnt_conv), .cnt_exc(cnt_exc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference conversion: exact value m*2^(e-150) rounded to the fp16 grid.
    function automatic logic [18:0] ref_cvt(input logic [31:0] x);
        logic   s;
        int     e, xe, ee, k;
        longint m, q, rem, half;
        logic [4:0] ef;
        logic [9:0] ff;
        s = x[31];
        e = int'(x[30:23]);
        if (e == 255)
            return (x[22:0] == 0) ? {3'b000, s, 5'h1F, 10'h0} : {3'b100, s, 5'h1F, x[22], 9'h1};
        if (e == 0)
            return {(x[22:0] != 0) ? 3'b001 : 3'b000, s, 15'h0};
        m  = longint'(x[22:0]) + (longint'(1) << 23);
        xe = e - 127;
        ee = (xe < -14) ? -14 : xe;
        k  = (ee - 10) - (e - 150);
        if (k >= 40) begin
            q = 0;
        end else begin
            q    = m >> k;
            rem  = m - (q << k);
            half = longint'(1) << (k - 1);
            if (rem > half || (rem == half && q[0])) q++;
        end
        if (q == 2048) begin
            q  = 1024;
            ee = ee + 1;
        end
        if (ee > 15)
            return {3'b010, s, 5'h1F, 10'h0};
        if (q < 1024) begin
            ff = 10'(q);
            return {3'b001, s, 5'h0, ff};
        end
        ef = 5'(ee + 15);
        ff = 10'(q - 1024);
        return {3'b000, s, ef, ff};
    endfunction

    // Transaction-level state of the block as the bench believes it to be.
    logic             m_valid;
    logic [15:0]      m_data;
    logic             m_src;
    logic [TAG_W-1:0] m_tag;
    logic [2:0]       m_flags;
    logic             m_last_b;
    int               m_conv, m_exc;

    task automatic cycle();
        logic can, ga, gb;
        logic [18:0] r;
        @(negedge clk);
        can = !m_valid || out_ready;
        ga  = a_valid && (!b_valid || m_last_b);
        gb  = b_valid && (!a_valid || !m_last_b);
        check("a_ready", 32'(a_ready), 32'(!rst && can && ga));
        check("b_ready", 32'(b_ready), 32'(!rst && can && gb));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_src", 32'(out_src), 32'(m_src));
            check("out_tag", 32'(out_tag), 32'(m_tag));
            check("out_flags", 32'(out_flags), 32'(m_flags));
        end
        check("cnt_conv", 32'(cnt_conv), 32'(m_conv));
        check("cnt_exc", 32'(cnt_exc), 32'(m_exc));
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = 0; m_src = 0; m_tag = 0; m_flags = 0;
            m_last_b = 1; m_conv = 0; m_exc = 0;
        end else begin
            r = 19'd0;
            if (can && (ga || gb)) begin
                r        = ref_cvt(gb ? b_data : a_data);
                m_valid  = 1;
                m_data   = r[15:0];
                m_flags  = r[18:16];
                m_src    = gb;
                m_tag    = gb ? b_tag : a_tag;
                m_last_b = gb;
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (clr_cnt) begin
                m_conv = 0; m_exc = 0;
            end else if (can && (ga || gb)) begin
                m_conv = (m_conv + 1) % (1 << CNT_W);
                if (r[18:16] != 0) m_exc = (m_exc + 1) % (1 << CNT_W);
            end
        end
        #1;
    endtask

    task automatic put(input logic av, input logic [31:0] ad, input logic [3:0] at,
                       input logic bv, input logic [31:0] bd, input logic [3:0] bt,
                       input logic ordy, input logic clr);
        a_valid = av; a_data = ad; a_tag = at;
        b_valid = bv; b_data = bd; b_tag = bt;
        out_ready = ordy; clr_cnt = clr;
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        case ($urandom_range(0, 5))
            0: e = 8'h00;
            1: e = 8'hFF;
            2: e = 8'(102 + $urandom_range(0, 12));
            3: e = 8'(140 + $urandom_range(0, 4));
            default: e = 8'($urandom_range(0, 255));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    initial begin
        m_valid = 0; m_data = 0; m_src = 0; m_tag = 0; m_flags = 0;
        m_last_b = 1; m_conv = 0; m_exc = 0;
        rst = 1;
        put(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(); cycle();
        rst = 0;
        cycle();

        put(1, 32'h3F800000, 4'h3, 0, 0, 0, 1, 0); cycle();
        check("one_data", 32'(out_data), 32'h3C00);
        check("one_cnt", 32'(cnt_conv), 32'd1);
        put(0, 0, 0, 1, 32'h477FF000, 4'h5, 1, 0); cycle();
        check("ovf_data", 32'(out_data), 32'h7C00);
        check("ovf_flags", 32'(out_flags), 32'b010);
        put(0, 0, 0, 1, 32'h33800000, 4'h6, 1, 0); cycle();
        check("min_sub", 32'(out_data), 32'h0001);
        check("min_sub_flags", 32'(out_flags), 32'b001);
        check("exc_cnt", 32'(cnt_exc), 32'd2);
        put(1, 32'h7FC00000, 4'h7, 0, 0, 0, 1, 0); cycle();
        check("nan_data", 32'(out_data), 32'h7E01);
        check("nan_flags", 32'(out_flags), 32'b100);
        put(1, 32'h80000000, 4'h8, 0, 0, 0, 1, 0); cycle();
        check("negzero", 32'(out_data), 32'h8000);
        check("negzero_flags", 32'(out_flags), 32'b000);

        // Continuous contention: sources must alternate with matching tags.
        put(1, 32'h40000000, 4'h1, 1, 32'hC0000000, 4'h2, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_valid", 32'(out_valid), 32'd1);
            check("rr_tag", 32'(out_tag), out_src ? 32'd2 : 32'd1);
        end

        // Stall with both pending, then release.
        put(1, 32'h3E000000, 4'h1, 1, 32'h42000000, 4'h2, 0, 0);
        for (int i = 0; i < 6; i++) cycle();
        out_ready = 1;
        cycle(); cycle();

        // Reset while holding a result, then contention after reset.
        out_ready = 0;
        for (int i = 0; i < 2; i++) cycle();
        rst = 1; cycle();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_cnt", 32'(cnt_conv), 32'd0);
        rst = 0;
        put(1, 32'h3F000000, 4'h9, 1, 32'h3F400000, 4'hA, 1, 0); cycle();
        check("post_rst_src", 32'(out_src), 32'd0);
        put(1, 32'h3F000000, 4'h9, 0, 0, 0, 1, 1); cycle();
        check("clr_xfer", 32'(cnt_conv), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            put(($urandom_range(0, 9) < 7), rand_fp(), 4'($urandom),
                ($urandom_range(0, 9) < 7), rand_fp(), 4'($urandom),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 0;
        put(0, 0, 0, 0, 0, 0, 1, 0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
